// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the uart_tx arbiter
//
// Purpose : arbiter FSM state encoding, tag byte base value, requester limit.
// Ports   : none (package).
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TAG   = 3'd1,
    LOAD  = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4
  } arb_state_t;

  // Tag byte is TAG_BASE | grant_index, so the index must fit in the low nibble.
  localparam logic [7:0] TAG_BASE = 8'hF0;
  localparam int         MAX_REQ  = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
//
// Purpose : choose the first asserted valid bit scanning upward from
//           last_i+1 (mod N_REQ), wrapping around to last_i itself.
// Ports   : valid_i  [N_REQ]  candidate requesters
//           last_i   [IW]     index granted most recently
//           onehot_o [N_REQ]  one-hot winner, 0 when none valid
//           idx_o    [IW]     binary winner index
//           any_o             at least one valid bit
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int          c;
  logic [IW-1:0] ci;

  // Scan from the farthest candidate down to the nearest so the nearest
  // valid index after last_i is the final (winning) assignment.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    c        = 0;
    ci       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c  = (int'(last_i) + k) % N_REQ;
      ci = IW'(c);
      if (valid_i[ci]) begin
        onehot_o     = '0;
        onehot_o[ci] = 1'b1;
        idx_o        = ci;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between byte streams
//
// Purpose : grants the serializer to one requester at a time, locked until the
//           packet's last byte or MAX_BURST bytes (0 = packet lock only), and
//           drives uart_tx data/start while honouring its busy flag.
// Macro   : UART_ARB_TAG_EN - when defined, each grant first sends the tag byte
//           8'hF0 | grant_index through the same start/guard/wait sequence.
// Ports   : clk, rstn            clock, synchronous active-low reset
//           req_data  [N_REQ][8] per-requester byte
//           req_valid [N_REQ]    byte available
//           req_last  [N_REQ]    byte ends packet
//           req_ready [N_REQ]    byte accepted when valid & ready
//           grant     [N_REQ]    one-hot owner, 0 when idle
//           tx_data   [8]        byte to uart_tx
//           tx_start             one-cycle start pulse to uart_tx
//           tx_busy              uart_tx busy (may rise a cycle after start)
//           arb_busy             arbiter not idle
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      grant,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  arb_busy
);

  localparam int            IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int            BW        = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             last_flag_q, last_flag_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  uart_rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .valid_i (req_valid),
    .last_i  (last_grant_q),
    .onehot_o(pick_onehot),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  logic accept;
  logic burst_hit;

  assign req_ready = (state_q == LOAD && !tx_busy) ? grant_q : '0;
  assign accept    = (state_q == LOAD) && !tx_busy && req_valid[gidx_q];
  assign burst_hit = (MAX_BURST != 0) && (beat_q == BURST_LIM);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    last_flag_d  = last_flag_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          beat_d  = '0;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        // Tag goes out like a data byte but never ends the grant or counts.
        if (!tx_busy) begin
          tx_data_d   = TAG_BASE | 8'(gidx_q);
          tx_start_d  = 1'b1;
          last_flag_d = 1'b0;
          state_d     = GUARD;
        end
      end
`endif
      LOAD: begin
        // Valid low keeps the grant: a packet is never split by a stall.
        if (accept) begin
          tx_data_d   = req_data[gidx_q];
          tx_start_d  = 1'b1;
          beat_d      = beat_q + BW'(1);
          last_flag_d = req_last[gidx_q];
          state_d     = GUARD;
        end
      end
      GUARD: begin
        // uart_tx may raise busy only now; ignore busy for this one cycle.
        state_d = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (last_flag_q || burst_hit) begin
            grant_d      = '0;
            last_grant_d = gidx_q;
            state_d      = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      beat_q       <= '0;
      last_flag_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      last_flag_q  <= last_flag_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic            clk;
  logic            rstn;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_valid;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic [1:0]      grant;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            arb_busy;

  uart_tx_arbiter #(
    .N_REQ    (2),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .arb_busy (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx model: busy rises the cycle after tx_start and lasts 4 cycles.
  logic       use_model;
  logic       tbl_busy;
  logic [2:0] mdl_cnt;
  always @(posedge clk) begin
    if (!rstn)               mdl_cnt <= 3'd0;
    else if (tx_start)       mdl_cnt <= 3'd4;
    else if (mdl_cnt != 3'd0) mdl_cnt <= mdl_cnt - 3'd1;
  end
  assign tx_busy = use_model ? (mdl_cnt != 3'd0) : tbl_busy;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] l;
    logic       b;
    logic [1:0] g;
    logic [1:0] r;
    logic       s;
    logic [7:0] dat;
    logic       ab;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] l, input logic b, input logic [1:0] g,
                     input logic [1:0] r, input logic s, input logic [7:0] dat, input logic ab);
    vec_t e;
    e.v = v; e.d0 = d0; e.d1 = d1; e.l = l; e.b = b;
    e.g = g; e.r = r; e.s = s; e.dat = dat; e.ab = ab;
    tbl.push_back(e);
  endtask

  // TAG, GUARD (start with tag byte), WAIT rows inserted after a grant.
  task automatic add_tag(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] l, input logic [1:0] g,
                         input logic [7:0] prev, input logic [7:0] tagb);
    add(v, d0, d1, l, 1'b0, g, 2'b00, 1'b0, prev, 1'b1);
    add(v, d0, d1, l, 1'b0, g, 2'b00, 1'b1, tagb, 1'b1);
    add(v, d0, d1, l, 1'b0, g, 2'b00, 1'b0, tagb, 1'b1);
  endtask

  // Requester sources, byte capture and protocol checks.
  logic        drv_en;
  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [11:0] cap_q[$];
  logic [11:0] exp_q[$];
  logic        prev_start;

  initial begin : drv
    logic [1:0] hs;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (tx_start) begin
        cap_q.push_back({(grant[1] ? 4'd1 : 4'd0), tx_data});
        chk("start_while_busy", 32'(tx_busy), 32'd0);
        chk("start_back_to_back", 32'(prev_start), 32'd0);
      end
      prev_start = tx_start;
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (hs[0] && src0.size() > 0) void'(src0.pop_front());
        if (hs[1] && src1.size() > 0) void'(src1.pop_front());
        req_valid[0] = (src0.size() > 0);
        req_data[0]  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
        req_last[0]  = (src0.size() > 0) ? src0[0][8] : 1'b0;
        req_valid[1] = (src1.size() > 0);
        req_data[1]  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
        req_last[1]  = (src1.size() > 0) ? src1[0][8] : 1'b0;
      end
    end
  end

  task automatic exp_grant(input int idx);
    if (TAGN != 0) exp_q.push_back({4'(idx), 8'hF0 | 8'(idx)});
  endtask

  task automatic exp_byte(input int idx, input logic [7:0] d);
    exp_q.push_back({4'(idx), d});
  endtask

  task automatic chk_stream(input string name);
    chk({name, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i),
          (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(src0.size() == 0 && src1.size() == 0 && !arb_busy && !tx_busy) && k < 3000);
    chk({name, "_idle_in_time"}, 32'(k < 3000), 32'd1);
    chk({name, "_grant_released"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_cap(input string name, input int n);
    int k;
    k = 0;
    while (cap_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_cap_in_time"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    src0.delete();
    src1.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cap_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] p1, p2;
    int         bad, sz;
    rstn = 1'b0; drv_en = 1'b0; use_model = 1'b0; tbl_busy = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);

    // Cycle table: req0 sends 41, 42(last) with a busy stall; req1 valid in
    // the release cycle gets the next grant after one idle bubble.
    p1 = (TAGN != 0) ? 8'hF0 : 8'h00;
    p2 = (TAGN != 0) ? 8'hF1 : 8'h42;
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    add(2'b01, 8'h41, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    if (TAGN != 0) add_tag(2'b01, 8'h41, 8'h00, 2'b00, 2'b01, 8'h00, 8'hF0);
    add(2'b01, 8'h41, 8'h00, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, p1, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h41, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h41, 1'b1);
    add(2'b01, 8'h42, 8'h00, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41, 1'b1);
    add(2'b01, 8'h42, 8'h00, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 8'h41, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h42, 1'b1);
    add(2'b10, 8'h00, 8'h77, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 8'h42, 1'b1);
    add(2'b10, 8'h00, 8'h77, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h42, 1'b0);
    if (TAGN != 0) add_tag(2'b10, 8'h00, 8'h77, 2'b10, 2'b10, 8'h42, 8'hF1);
    add(2'b10, 8'h00, 8'h77, 2'b10, 1'b0, 2'b10, 2'b10, 1'b0, p2, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 8'h77, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h77, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h77, 1'b0);

    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v; req_data[0] = tbl[i].d0; req_data[1] = tbl[i].d1;
      req_last = tbl[i].l; tbl_busy = tbl[i].b;
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].r));
      chk($sformatf("row%0d_tx_start", i), 32'(tx_start), 32'(tbl[i].s));
      chk($sformatf("row%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].dat));
      chk($sformatf("row%0d_arb_busy", i), 32'(arb_busy), 32'(tbl[i].ab));
      @(posedge clk);
      #1;
    end

    drv_en = 1'b1;
    use_model = 1'b1;

    // Single requester, three-byte packet.
    do_reset();
    src0.push_back({1'b0, 8'h41}); src0.push_back({1'b0, 8'h42}); src0.push_back({1'b1, 8'h43});
    exp_grant(0); exp_byte(0, 8'h41); exp_byte(0, 8'h42); exp_byte(0, 8'h43);
    wait_idle("single");
    chk("single_arb_busy", 32'(arb_busy), 32'd0);
    chk_stream("single");

    // Two requesters, two 2-byte packets each: whole packets alternate.
    do_reset();
    src0.push_back({1'b0, 8'hA0}); src0.push_back({1'b1, 8'hA1});
    src0.push_back({1'b0, 8'hA2}); src0.push_back({1'b1, 8'hA3});
    src1.push_back({1'b0, 8'hB0}); src1.push_back({1'b1, 8'hB1});
    src1.push_back({1'b0, 8'hB2}); src1.push_back({1'b1, 8'hB3});
    exp_grant(0); exp_byte(0, 8'hA0); exp_byte(0, 8'hA1);
    exp_grant(1); exp_byte(1, 8'hB0); exp_byte(1, 8'hB1);
    exp_grant(0); exp_byte(0, 8'hA2); exp_byte(0, 8'hA3);
    exp_grant(1); exp_byte(1, 8'hB2); exp_byte(1, 8'hB3);
    wait_idle("rr");
    chk_stream("rr");

    // Burst limit 4: 10-byte packet from req0 is split around req1's packet.
    do_reset();
    for (int i = 0; i < 10; i++) src0.push_back({(i == 9), 8'(8'h10 + i)});
    src1.push_back({1'b0, 8'hC0}); src1.push_back({1'b1, 8'hC1});
    exp_grant(0);
    for (int i = 0; i < 4; i++) exp_byte(0, 8'(8'h10 + i));
    exp_grant(1); exp_byte(1, 8'hC0); exp_byte(1, 8'hC1);
    exp_grant(0);
    for (int i = 4; i < 8; i++) exp_byte(0, 8'(8'h10 + i));
    exp_grant(0);
    for (int i = 8; i < 10; i++) exp_byte(0, 8'(8'h10 + i));
    wait_idle("burst");
    chk_stream("burst");

    // Packet lock: req0 stalls mid-packet for 50 cycles, req1 must wait.
    do_reset();
    src0.push_back({1'b0, 8'h10});
    src1.push_back({1'b1, 8'h20});
    wait_cap("lock", 1 + TAGN);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (grant !== 2'b01 || req_ready[1] !== 1'b0 || tx_start !== 1'b0) bad++;
    end
    chk("lock_window_violations", 32'(bad), 32'd0);
    src0.push_back({1'b0, 8'h11}); src0.push_back({1'b1, 8'h12});
    exp_grant(0); exp_byte(0, 8'h10); exp_byte(0, 8'h11); exp_byte(0, 8'h12);
    exp_grant(1); exp_byte(1, 8'h20);
    wait_idle("lock");
    chk_stream("lock");

    // Reset while req1's byte is in WAIT; round-robin pointer must restart.
    do_reset();
    src0.push_back({1'b1, 8'h30});
    src1.push_back({1'b1, 8'h31});
    wait_cap("rstwait", 2 * (1 + TAGN));
    bad = 0;
    while (!(tx_busy && arb_busy) && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    chk("rstwait_reached_wait", 32'(tx_busy && arb_busy), 32'd1);
    sz = cap_q.size();
    rstn = 1'b0;
    @(negedge clk);
    chk("rstwait_grant", 32'(grant), 32'd0);
    chk("rstwait_tx_start", 32'(tx_start), 32'd0);
    chk("rstwait_arb_busy", 32'(arb_busy), 32'd0);
    chk("rstwait_ready", 32'(req_ready), 32'd0);
    chk("rstwait_no_pulse", 32'(cap_q.size()), 32'(sz));
    rstn = 1'b1;
    cap_q.delete();
    src0.push_back({1'b1, 8'h66});
    src1.push_back({1'b1, 8'h77});
    exp_grant(0); exp_byte(0, 8'h66); exp_grant(1); exp_byte(1, 8'h77);
    wait_idle("after_rst");
    chk_stream("after_rst");

    // Lone req1 single-byte packet (tag F1 precedes it when tagging is on).
    do_reset();
    src1.push_back({1'b1, 8'h55});
    exp_grant(1); exp_byte(1, 8'h55);
    wait_idle("req1_only");
    chk_stream("req1_only");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte-stream requesters, e.g. CPU output port, trace buffer and debug monitor.
- Per-requester valid/ready/last stream.
- Round-robin grant, locked for a whole packet (until last) or MAX_BURST bytes.
- Drives the serializer's data/tx_start inputs and observes its tx_busy.
- Sits between the requesters and uart_tx; replaces ad-hoc direct drive of tx_start.

Parameters:
N_REQ, 2, number of requesters (1..16)
MAX_BURST, 16, max bytes per grant before forced re-arbitration; 0 = unlimited (packet lock only)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
req_data  input  N_REQ x 8  per-requester byte
req_valid  input  N_REQ  byte available
req_last  input  N_REQ  byte ends packet (sampled with valid)
req_ready  output  N_REQ  byte accepted when valid & ready
grant  output  N_REQ  one-hot current owner, 0 when idle
tx_data  output  8  byte to uart_tx
tx_start  output  1  one-cycle start pulse to uart_tx
tx_busy  input  1  uart_tx busy (may rise one cycle after tx_start)
arb_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: tx_data=0, tx_start=0, grant=0, req_ready=0, state=IDLE, last_grant=N_REQ-1 (so index 0 wins first), beat_cnt=0.
- Reset mid-transfer: return to reset values next cycle; no tx_start pulse issued; the partial packet is dropped.
- IDLE:
  - If any req_valid, pick the first valid index scanning from last_grant+1 mod N_REQ upward.
  - Register grant one-hot and clear beat_cnt, then go to LOAD.
  - No valid: stay in IDLE.
- LOAD:
  - req_ready[g] = (state==LOAD) & ~tx_busy; combinational, granted index only; all other ready bits are 0.
  - On accept: tx_data<=req_data[g], tx_start<=1 (next cycle only), beat_cnt+1, last_flag<=req_last[g], go to GUARD.
  - Valid low: stay in LOAD holding the grant. This packet lock is intentional; no timeout.
- GUARD: exactly one cycle, masks tx_busy rise latency; tx_start cleared here; go to WAIT.
- WAIT: when tx_busy==0:
  - If last_flag, or (MAX_BURST!=0 and beat_cnt==MAX_BURST): grant<=0, last_grant<=g, go to IDLE.
  - Otherwise go to LOAD.
- Latency:
  - Valid in IDLE at cycle T -> grant at T+1, ready at T+1 (if ~tx_busy).
  - Accept at T -> tx_start=1 exactly during T+1.
  - tx_data holds from T+1 until the next accept.
- tx_start is never high two consecutive cycles; it never asserts while tx_busy=1.
- Release boundary: a requester valid in the release cycle is considered in the following IDLE cycle (one bubble).
- Simultaneous requests resolve round-robin only; the same index cannot win twice in a row while another is valid.
- beat_cnt width: $clog2(MAX_BURST+1); a minimum of 1 bit when MAX_BURST=0 (counter unused).

Optional Feature:
UART_ARB_TAG_EN:
- Defined: after each grant, a TAG state sends 8'hF0 | grant_index before the first data byte. It uses the same start/GUARD/WAIT sequence and does not count toward beat_cnt. Receiver demultiplexes streams; N_REQ must be <=16.
- Undefined: no TAG state; data bytes only.

Decomposition:
- Package uart_arb_pkg: arb_state_t enum (IDLE, TAG, LOAD, GUARD, WAIT), TAG_BASE=8'hF0, MAX_REQ=16.
- Sub-module uart_rr_pick: combinational round-robin picker (valid vector, last index -> one-hot, any).

Test Plan:
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with model uart_tx -> 3 single-cycle tx_start pulses, tx_data in order, grant drops after third busy fall.
- Req 0 and 1 valid from reset, each 2-byte packets, repeated -> order 0,1,0,1; no byte interleaving inside a packet.
- MAX_BURST=4, req 0 sends a 10-byte packet, req 1 valid -> 4 bytes from 0, then 1's packet, then remainder of 0.
- Req 0 drops valid mid-packet for 50 cycles while req 1 valid -> grant stays 0, req_ready[1]=0, no tx_start until 0 resumes.
- rstn low during WAIT -> next cycle grant=0, tx_start=0, arb_busy=0; new request afterwards granted to index 0.
- UART_ARB_TAG_EN, req 1 sends 0x55 last -> bytes 0xF1 then 0x55.
